// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern source and its matching detectors.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } seq_state_t;

  // Default pattern. The detector blocks import the same values, so the
  // source and the sink cannot drift apart.
  localparam int                   SEQ_PAT_W    = 5;
  localparam logic [SEQ_PAT_W-1:0] SEQ_PATTERN  = 5'b11011;
  localparam int                   SEQ_OVL_SKIP = 2;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Control/serial bundle between a requester and seq_pattern_tx.
// Latency: n/a (wires only).
// Backpressure: none; the stream is fire-and-forget, and start is ignored while busy.
// Ports: master drives start/reps/ovl/gap and observes the stream;
//        slave (the transmitter) drives sout/sout_vld/occ_end/busy/done.
interface seq_pattern_tx_if #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic             start;
  logic [CNT_W-1:0] reps;
  logic             ovl;
  logic [GAP_W-1:0] gap;
  logic             sout;
  logic             sout_vld;
  logic             occ_end;
  logic             busy;
  logic             done;

  modport master (
    output start, reps, ovl, gap,
    input  sout, sout_vld, occ_end, busy, done
  );

  modport slave (
    input  start, reps, ovl, gap,
    output sout, sout_vld, occ_end, busy, done
  );
endinterface

// File: rtl/seq_bit_counter.sv
// Loadable saturating down-counter with a zero flag for the current value.
// Latency: the count updates on the edge after load/dec; cnt_nxt shows that value combinationally.
// Backpressure: none; load has priority over dec, and dec at zero holds zero.
// Ports: clk, rst (sync, active high), load/load_val, dec -> cnt_nxt, zero.
module seq_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt_nxt,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_comb begin
    cnt_nxt = cnt;
    if (load) begin
      cnt_nxt = load_val;
    end else if (dec && (cnt != '0)) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/seq_pattern_tx.sv
// Bit-serial pattern source: emits PATTERN (MSB first) reps times, with gaps or overlapped.
// Latency: the first bit is on sout the cycle after start is sampled; done follows the last bit.
// Backpressure: none; start is ignored unless IDLE, and rst abandons a transfer without done.
// Ports: clk, rst (sync, active high); bus (slave): start/reps/ovl/gap in, sout/sout_vld/occ_end/busy/done out.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W    = SEQ_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN  = SEQ_PATTERN,
  parameter int               OVL_SKIP = SEQ_OVL_SKIP,
  parameter int               CNT_W    = 8,
  parameter int               GAP_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  seq_pattern_tx_if.slave  bus
);
  localparam int IDX_W = $clog2(PAT_W);

  seq_state_t       state, state_nxt;
  logic             ovl_q;
  logic [GAP_W-1:0] gap_q;
  logic             start_acc;

  logic             idx_load, idx_dec, idx_zero;
  logic [IDX_W-1:0] idx_val, idx_nxt;
  logic             rem_load, rem_dec, rem_zero;
  logic [CNT_W-1:0] rem_nxt;
  logic             gap_load, gap_dec, gap_zero;
  logic [GAP_W-1:0] gap_nxt;

  // idx: index of the bit currently on sout. rem: occurrences still owed,
  // counting the current one. gap: zero bits still owed, counting the current one.
  seq_bit_counter #(.W(IDX_W)) u_idx (
    .clk(clk), .rst(rst), .load(idx_load), .load_val(idx_val),
    .dec(idx_dec), .cnt_nxt(idx_nxt), .zero(idx_zero)
  );

  seq_bit_counter #(.W(CNT_W)) u_rem (
    .clk(clk), .rst(rst), .load(rem_load), .load_val(bus.reps),
    .dec(rem_dec), .cnt_nxt(rem_nxt), .zero(rem_zero)
  );

  seq_bit_counter #(.W(GAP_W)) u_gap (
    .clk(clk), .rst(rst), .load(gap_load), .load_val(gap_q),
    .dec(gap_dec), .cnt_nxt(gap_nxt), .zero(gap_zero)
  );

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    idx_load  = 1'b0;
    idx_dec   = 1'b0;
    idx_val   = IDX_W'(PAT_W - 1);
    rem_load  = 1'b0;
    rem_dec   = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.reps != '0) begin
            start_acc = 1'b1;
            rem_load  = 1'b1;
            idx_load  = 1'b1;
            state_nxt = SEND;
          end else begin
            state_nxt = FIN;
          end
        end
      end

      SEND: begin
        if (idx_zero) begin
          rem_dec = 1'b1;
          // rem_zero only guards against a counter that is already empty.
          if ((rem_nxt == '0) || rem_zero) begin
            state_nxt = FIN;
          end else if (ovl_q) begin
            // Resume past the shared prefix: no bubble, gap ignored.
            idx_load = 1'b1;
            idx_val  = IDX_W'(PAT_W - 1 - OVL_SKIP);
          end else if (gap_q != '0) begin
            gap_load  = 1'b1;
            state_nxt = GAP;
          end else begin
            idx_load = 1'b1;
          end
        end else begin
          idx_dec = 1'b1;
        end
      end

      GAP: begin
        gap_dec = 1'b1;
        if ((gap_nxt == '0) || gap_zero) begin
          idx_load  = 1'b1;
          state_nxt = SEND;
        end
      end

      FIN: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are registered from the state and index being entered, so they
  // line up with the cycle in which that state is current.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovl_q        <= 1'b0;
      gap_q        <= '0;
      bus.sout     <= 1'b0;
      bus.sout_vld <= 1'b0;
      bus.occ_end  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      if (start_acc) begin
        ovl_q <= bus.ovl;
        gap_q <= bus.gap;
      end
      bus.sout     <= (state_nxt == SEND) ? PATTERN[idx_nxt] : 1'b0;
      bus.sout_vld <= (state_nxt == SEND) || (state_nxt == GAP);
      bus.occ_end  <= (state_nxt == SEND) && (idx_nxt == '0);
      bus.busy     <= (state_nxt == SEND) || (state_nxt == GAP);
      bus.done     <= (state_nxt == FIN);
    end
  end
endmodule

// File: tb/tb_seq_pattern_tx.sv
module tb_seq_pattern_tx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_pattern_tx_if #(.CNT_W(8), .GAP_W(4)) bus_if ();

  seq_pattern_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Overlapping 11011 detector fed from the serial stream; hit is registered.
  logic [4:0] det_sh;
  logic       det_hit;
  always @(posedge clk) begin
    if (rst) begin
      det_sh  <= 5'b0;
      det_hit <= 1'b0;
    end else if (bus_if.sout_vld) begin
      det_sh  <= {det_sh[3:0], bus_if.sout};
      det_hit <= ({det_sh[3:0], bus_if.sout} == 5'b11011);
    end else begin
      det_hit <= 1'b0;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  reps;
    logic        ovl;
    logic [3:0]  gap;
    int          len;
    logic [31:0] bits;
    logic [31:0] occ;
  } vec_t;

  vec_t vecs[7];

  // Pulses start, then checks every emitted bit, the done pulse and the return to idle.
  task automatic run_vec(input int id, input vec_t v);
    bus_if.reps  = v.reps;
    bus_if.ovl   = v.ovl;
    bus_if.gap   = v.gap;
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    for (int i = 0; i < v.len; i++) begin
      chk($sformatf("v%0d bit%0d vld", id, i + 1), 32'(bus_if.sout_vld), 32'd1);
      chk($sformatf("v%0d bit%0d sout", id, i + 1), 32'(bus_if.sout), 32'(v.bits[v.len-1-i]));
      chk($sformatf("v%0d bit%0d occ_end", id, i + 1), 32'(bus_if.occ_end), 32'(v.occ[v.len-1-i]));
      chk($sformatf("v%0d bit%0d busy", id, i + 1), 32'(bus_if.busy), 32'd1);
      chk($sformatf("v%0d bit%0d done", id, i + 1), 32'(bus_if.done), 32'd0);
      step();
    end
    chk($sformatf("v%0d fin done", id), 32'(bus_if.done), 32'd1);
    chk($sformatf("v%0d fin busy", id), 32'(bus_if.busy), 32'd0);
    chk($sformatf("v%0d fin vld", id), 32'(bus_if.sout_vld), 32'd0);
    step();
    chk($sformatf("v%0d idle done", id), 32'(bus_if.done), 32'd0);
    chk($sformatf("v%0d idle vld", id), 32'(bus_if.sout_vld), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] exp_r;
    int          n_vld, n_occ, cyc, hits;
    logic        prev_occ;

    vecs[0] = '{8'd1, 1'b0, 4'd0, 5,  32'b11011,        32'b00001};
    vecs[1] = '{8'd2, 1'b0, 4'd2, 12, 32'b110110011011, 32'b000010000001};
    vecs[2] = '{8'd3, 1'b1, 4'd7, 11, 32'b11011011011,  32'b00001001001};
    vecs[3] = '{8'd0, 1'b0, 4'd0, 0,  32'b0,            32'b0};
    vecs[4] = '{8'd2, 1'b0, 4'd0, 10, 32'b1101111011,   32'b0000100001};
    vecs[5] = '{8'd2, 1'b1, 4'd3, 8,  32'b11011011,     32'b00001001};
    vecs[6] = '{8'd1, 1'b1, 4'd5, 5,  32'b11011,        32'b00001};

    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.reps  = 8'd0;
    bus_if.ovl   = 1'b0;
    bus_if.gap   = 4'd0;
    repeat (3) step();
    chk("reset sout", 32'(bus_if.sout), 32'd0);
    chk("reset vld", 32'(bus_if.sout_vld), 32'd0);
    chk("reset occ_end", 32'(bus_if.occ_end), 32'd0);
    chk("reset busy", 32'(bus_if.busy), 32'd0);
    chk("reset done", 32'(bus_if.done), 32'd0);
    rst = 1'b0;
    step();

    for (int k = 0; k < 7; k++) begin
      run_vec(k, vecs[k]);
      step();
    end

    // start during FIN is dropped, not queued.
    bus_if.reps  = 8'd0;
    bus_if.start = 1'b1;
    step();
    chk("fin-start done", 32'(bus_if.done), 32'd1);
    bus_if.reps = 8'd2;
    step();
    bus_if.start = 1'b0;
    chk("fin-start vld", 32'(bus_if.sout_vld), 32'd0);
    chk("fin-start busy", 32'(bus_if.busy), 32'd0);
    step();
    chk("fin-start later busy", 32'(bus_if.busy), 32'd0);

    // Second start mid-transfer ignored, then reset abandons the transfer.
    exp_r = 20'b11011110111101111011;
    bus_if.reps  = 8'd4;
    bus_if.ovl   = 1'b0;
    bus_if.gap   = 4'd0;
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      chk($sformatf("abort bit%0d sout", i), 32'(bus_if.sout), 32'(exp_r[20-i]));
      chk($sformatf("abort bit%0d vld", i), 32'(bus_if.sout_vld), 32'd1);
      chk($sformatf("abort bit%0d occ_end", i), 32'(bus_if.occ_end), (i == 5) ? 32'd1 : 32'd0);
      if (i == 3) begin
        bus_if.start = 1'b1;
        bus_if.reps  = 8'd1;
        bus_if.ovl   = 1'b1;
        bus_if.gap   = 4'd3;
      end else begin
        bus_if.start = 1'b0;
      end
      if (i == 9) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    chk("abort sout", 32'(bus_if.sout), 32'd0);
    chk("abort vld", 32'(bus_if.sout_vld), 32'd0);
    chk("abort occ_end", 32'(bus_if.occ_end), 32'd0);
    chk("abort busy", 32'(bus_if.busy), 32'd0);
    chk("abort done", 32'(bus_if.done), 32'd0);
    step();
    chk("abort later done", 32'(bus_if.done), 32'd0);
    chk("abort later vld", 32'(bus_if.sout_vld), 32'd0);
    run_vec(100, vecs[0]);

    // start together with rst: reset wins.
    bus_if.reps  = 8'd1;
    bus_if.start = 1'b1;
    rst          = 1'b1;
    step();
    bus_if.start = 1'b0;
    rst          = 1'b0;
    chk("rst+start busy", 32'(bus_if.busy), 32'd0);
    chk("rst+start vld", 32'(bus_if.sout_vld), 32'd0);
    step();
    chk("rst+start later vld", 32'(bus_if.sout_vld), 32'd0);
    chk("rst+start later done", 32'(bus_if.done), 32'd0);

    // Maximum repetition count, overlapped.
    bus_if.reps  = 8'd255;
    bus_if.ovl   = 1'b1;
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    n_vld = 0;
    n_occ = 0;
    cyc   = 0;
    while (!bus_if.done && cyc < 2000) begin
      if (bus_if.sout_vld) n_vld++;
      if (bus_if.occ_end) n_occ++;
      cyc++;
      step();
    end
    chk("max reps done seen", 32'(bus_if.done), 32'd1);
    chk("max reps bit count", 32'(n_vld), 32'd767);
    chk("max reps occ count", 32'(n_occ), 32'd255);
    step();

    // Loopback into the detector: one hit per occurrence, one cycle after occ_end.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus_if.reps  = 8'd3;
    bus_if.ovl   = 1'b1;
    bus_if.gap   = 4'd7;
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    hits     = 0;
    prev_occ = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      chk($sformatf("loop c%0d hit", c), 32'(det_hit), 32'(prev_occ));
      if (det_hit) hits++;
      prev_occ = bus_if.occ_end;
      step();
    end
    chk("loop hit count", 32'(hits), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
